// File: rtl/canvas_pkg.sv
// Shared types and default geometry for the canvas sequencer.
// Build option CANVAS_BRUSH_3X3_EN (see canvas_sequencer) widens the brush.
package canvas_pkg;
  localparam int GRID           = 28;
  localparam int CANVAS_X0_DEF  = 96;
  localparam int CANVAS_Y0_DEF  = 16;
  localparam int CELL_SHIFT_DEF = 4;
  localparam int IDLE_FRAMES    = 45;

  typedef logic [27:0] canvas_row_t;

  typedef enum logic [2:0] {
    IDLE,
    DRAW,
    READY,
    SUBMIT,
    WAIT_NN,
    SHOW
  } canvas_state_t;
endpackage

// File: rtl/canvas_cell_map.sv
// Pixel to canvas-cell mapping; also used by the VGA overlay.
// gx/gy read 0 whenever the pointer is outside the canvas.
module canvas_cell_map #(
  parameter int CANVAS_X0  = canvas_pkg::CANVAS_X0_DEF,
  parameter int CANVAS_Y0  = canvas_pkg::CANVAS_Y0_DEF,
  parameter int CELL_SHIFT = canvas_pkg::CELL_SHIFT_DEF,
  parameter int GRID       = canvas_pkg::GRID
)(
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  output logic [4:0] gx,
  output logic [4:0] gy,
  output logic       in_canvas
);
  import canvas_pkg::*;

  localparam int SPAN = GRID << CELL_SHIFT;

  logic [9:0] dx;
  logic [9:0] dy;
  logic       in_x;
  logic       in_y;

  always_comb begin
    in_x = ({1'b0, x_pos} >= 11'(CANVAS_X0)) &&
           ({1'b0, x_pos} <  11'(CANVAS_X0 + SPAN));
    in_y = ({1'b0, y_pos} >= 11'(CANVAS_Y0)) &&
           ({1'b0, y_pos} <  11'(CANVAS_Y0 + SPAN));
    in_canvas = in_x && in_y;
    dx = x_pos - 10'(CANVAS_X0);
    dy = y_pos - 10'(CANVAS_Y0);
    gx = '0;
    gy = '0;
    if (in_canvas) begin
      gx = 5'(dx >> CELL_SHIFT);
      gy = 5'(dy >> CELL_SHIFT);
    end
  end
endmodule

// File: rtl/canvas_sequencer.sv
// Draw / submit / classify sequencer with a 28x28 flop canvas.
// Define CANVAS_BRUSH_3X3_EN for a 3x3 brush clipped at the grid edges.
module canvas_sequencer #(
  parameter int CANVAS_X0   = canvas_pkg::CANVAS_X0_DEF,
  parameter int CANVAS_Y0   = canvas_pkg::CANVAS_Y0_DEF,
  parameter int CELL_SHIFT  = canvas_pkg::CELL_SHIFT_DEF,
  parameter int GRID        = canvas_pkg::GRID,
  parameter int IDLE_FRAMES = canvas_pkg::IDLE_FRAMES
)(
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [9:0]  X_pos,
  input  logic [9:0]  Y_pos,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        nn_ready,
  output logic        nn_start,
  input  logic        nn_done,
  input  logic [3:0]  nn_digit,
  input  logic [4:0]  rd_row,
  output logic [27:0] rd_bits,
  output logic        busy,
  output logic        result_valid,
  output logic [3:0]  result_digit
);
  import canvas_pkg::*;

  canvas_state_t state_q, state_d;
  canvas_row_t   canvas_q [GRID];
  canvas_row_t   canvas_d [GRID];
  logic [7:0]    idle_cnt_q, idle_cnt_d;
  logic          clear_pend_q, clear_pend_d;
  logic          result_valid_q, result_valid_d;
  logic [3:0]    result_digit_q, result_digit_d;
  logic          nn_start_q, nn_start_d;
  logic          busy_q, busy_d;

  logic [4:0]      gx, gy;
  logic            in_canvas;
  logic            paint_state, press, paint_en;
  logic            clr_now, done_ok, drop, wipe;
  canvas_row_t     col_mask;
  logic [GRID-1:0] row_hit;

  canvas_cell_map #(
    .CANVAS_X0 (CANVAS_X0),
    .CANVAS_Y0 (CANVAS_Y0),
    .CELL_SHIFT(CELL_SHIFT),
    .GRID      (GRID)
  ) u_cell_map (
    .x_pos    (X_pos),
    .y_pos    (Y_pos),
    .gx       (gx),
    .gy       (gy),
    .in_canvas(in_canvas)
  );

  // Clear beats paint; a clear seen while frozen drops the next result.
  always_comb begin
    paint_state = (state_q == IDLE) || (state_q == DRAW) ||
                  (state_q == READY) || (state_q == SHOW);
    press    = btn_left && in_canvas && !btn_right;
    paint_en = paint_state && press;
    clr_now  = paint_state && btn_right;
    done_ok  = (state_q == WAIT_NN) && nn_done;
    drop     = done_ok && (clear_pend_q || btn_right);
    wipe     = clr_now || drop;
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (press) state_d = DRAW;
      DRAW:    if (!btn_left) state_d = READY;
      READY: begin
        if (press)
          state_d = DRAW;
        else if (idle_cnt_q == 8'(IDLE_FRAMES - 1))
          state_d = SUBMIT;
      end
      SUBMIT:  if (nn_ready) state_d = WAIT_NN;
      WAIT_NN: if (nn_done) state_d = drop ? IDLE : SHOW;
      SHOW:    if (press) state_d = DRAW;
      default: state_d = IDLE;
    endcase
    if (clr_now) state_d = IDLE;
  end

  always_comb begin
    idle_cnt_d = '0;
    if (state_q == READY && state_d == READY)
      idle_cnt_d = idle_cnt_q + 8'd1;

    clear_pend_d = 1'b0;
    if ((state_q == SUBMIT || state_q == WAIT_NN) && !done_ok)
      clear_pend_d = clear_pend_q || btn_right;

    result_valid_d = result_valid_q;
    result_digit_d = result_digit_q;
    if (done_ok && !drop) begin
      result_valid_d = 1'b1;
      result_digit_d = nn_digit;
    end
    if (wipe || (state_q == SHOW && press))
      result_valid_d = 1'b0;

    nn_start_d = (state_d == SUBMIT);
    busy_d     = (state_d == SUBMIT) || (state_d == WAIT_NN);
  end

  always_comb begin
    col_mask = canvas_row_t'(1) << gx;
`ifdef CANVAS_BRUSH_3X3_EN
    col_mask = col_mask | (col_mask << 1) | (col_mask >> 1);
`endif
    for (int r = 0; r < GRID; r++) begin
      row_hit[r] = (r == int'(gy));
`ifdef CANVAS_BRUSH_3X3_EN
      row_hit[r] = row_hit[r] || (r == int'(gy) - 1) ||
                   (r == int'(gy) + 1);
`endif
    end
  end

  always_comb begin
    canvas_d = canvas_q;
    for (int r = 0; r < GRID; r++) begin
      if (wipe)
        canvas_d[r] = '0;
      else if (paint_en && row_hit[r])
        canvas_d[r] = canvas_q[r] | col_mask;
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      canvas_q       <= '{default: '0};
      idle_cnt_q     <= '0;
      clear_pend_q   <= 1'b0;
      result_valid_q <= 1'b0;
      result_digit_q <= '0;
      nn_start_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      canvas_q       <= canvas_d;
      idle_cnt_q     <= idle_cnt_d;
      clear_pend_q   <= clear_pend_d;
      result_valid_q <= result_valid_d;
      result_digit_q <= result_digit_d;
      nn_start_q     <= nn_start_d;
      busy_q         <= busy_d;
    end
  end

  assign rd_bits      = (int'(rd_row) < GRID) ? canvas_q[rd_row] : '0;
  assign nn_start     = nn_start_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign result_digit = result_digit_q;
endmodule

// File: doc/canvas_sequencer.md
# canvas_sequencer

Sequences the drawing-and-classify flow on the `frame_clk` domain. Each frame it takes the pointer position and mouse buttons and paints cells of a 28×28 binary canvas held in flops. It submits the finished digit to the NN core after an idle timeout and latches the classification result. Its inputs come from the pointer datapath. Its canvas read port feeds both the NN input loader and the VGA overlay.

## Interface
Parameters:
- `CANVAS_X0`, 96: left pixel of the canvas region.
- `CANVAS_Y0`, 16: top pixel of the canvas region.
- `CELL_SHIFT`, 4: log2 of the cell size in pixels, so cells are 16×16 and the region is 448×448.
- `GRID`, 28: cells per side.
- `IDLE_FRAMES`, 45: frames without painting before auto-submit.

Ports:
- `frame_clk` in 1: clock, one edge per video frame.
- `Reset` in 1: asynchronous, active-high.
- `X_pos`, `Y_pos` in 10: pointer pixel position.
- `btn_left` in 1: paint button, level.
- `btn_right` in 1: clear button, level.
- `nn_ready` in 1: NN core accepts a start request.
- `nn_start` out 1: start request, held until accepted.
- `nn_done` in 1: one-cycle completion pulse.
- `nn_digit` in 4: class, valid with `nn_done`.
- `rd_row` in 5: canvas row select, 0..27.
- `rd_bits` out 28: combinational row contents; bit k is column k; rows ≥28 read 0.
- `busy` out 1: high in SUBMIT or WAIT_NN.
- `result_valid` out 1: `result_digit` holds a current classification.
- `result_digit` out 4: last classification.

## Operation
States and transitions:
- IDLE: canvas empty. `btn_left` in-canvas goes to DRAW.
- DRAW: paints while `btn_left` is high. On release, go to READY.
- READY: `idle_cnt` increments per frame. `btn_left` in-canvas returns to DRAW and zeroes `idle_cnt`. When `idle_cnt == IDLE_FRAMES-1`, go to SUBMIT.
- SUBMIT: `nn_start=1`. On an edge with `nn_ready=1`, go to WAIT_NN.
- WAIT_NN: on `nn_done`, latch `result_digit <= nn_digit`, set `result_valid=1` and go to SHOW.
- SHOW: `btn_left` in-canvas clears `result_valid`, paints, and goes to DRAW. Existing strokes are kept.

Cell mapping:
- In-canvas means `CANVAS_X0 <= X_pos < CANVAS_X0+(GRID<<CELL_SHIFT)`, and the same on Y.
- `gx = (X_pos-CANVAS_X0)>>CELL_SHIFT` and `gy` likewise, using 10-bit unsigned subtraction, evaluated only when in-canvas.
- Out-of-canvas presses paint nothing and cause no transition.

Painting:
- Sets bits, never clears them.
- Allowed only in IDLE, DRAW, READY and SHOW.
- The canvas is frozen in SUBMIT and WAIT_NN, so the NN reads stable data.

Clear (`btn_right`):
- In IDLE, DRAW, READY or SHOW: on the next edge all 784 bits go to 0, the state goes to IDLE, `result_valid=0` and `idle_cnt=0`.
- In SUBMIT or WAIT_NN: sets `clear_pend`. When `nn_done` arrives, clear the canvas, go to IDLE and leave `result_valid=0`, discarding the result.
- `btn_left` and `btn_right` both high: clear wins and nothing is painted.

Reset:
- Asynchronous.
- Canvas 0, state IDLE, `idle_cnt` 0, `clear_pend` 0.
- Outputs: `nn_start` 0, `busy` 0, `result_valid` 0, `result_digit` 0.
- A reset mid-inference drops the request. A later `nn_done` seen in IDLE is ignored.

## Timing
- A paint sampled on edge N is visible on `rd_bits` after edge N.
- `nn_start` and `busy` are registered and decoded from state, so they go high in the cycle after the READY→SUBMIT edge.
- The request is accepted on the first edge with `nn_ready=1`, and `nn_start` drops after that edge.
- Auto-submit latency: SUBMIT is entered exactly `IDLE_FRAMES` edges after the release edge.
- `nn_done` outside WAIT_NN is ignored.
- `result_digit` holds its value until the next `nn_done` in WAIT_NN or until Reset.

## Configuration
- `CANVAS_BRUSH_3X3_EN` defined: each paint sets the 3×3 neighbourhood around `(gx,gy)`, clipped at grid edges. Painting (0,0) sets 4 cells; (27,13) sets 6.
- Undefined: only cell `(gx,gy)` is set.

## Structure
- Package `canvas_pkg` holds:
  - the `canvas_state_t` enum (IDLE, DRAW, READY, SUBMIT, WAIT_NN, SHOW);
  - `GRID`, the default canvas geometry and `IDLE_FRAMES`;
  - the `canvas_row_t` typedef (`logic [27:0]`).
- Sub-module `canvas_cell_map`: combinational pixel→cell mapping producing `gx`, `gy` and `in_canvas`. It is shared with the VGA overlay.

## Test plan
- Reset, then `btn_left=1` at (96,16) for 1 frame → `rd_bits` for row 0 = 28'h0000001. State DRAW, then READY after release.
- Paint at (543,463) → row 27 bit 27 set. Paint at (95,16) and at (544,100) → canvas unchanged.
- Release, hold `nn_ready=0` for 10 frames after SUBMIT, then raise it → `nn_start` high for the 45th frame through the acceptance edge. Then pulse `nn_done` with `nn_digit=7` → `result_valid=1`, `result_digit=7`, `busy=0`.
- `btn_right` during WAIT_NN, then `nn_done` with `nn_digit=3` → canvas all 0, IDLE, `result_valid=0`, `result_digit` unchanged.
- `btn_left` and `btn_right` together in DRAW → canvas 0, IDLE. Assert Reset mid-SUBMIT → `nn_start=0` immediately.
- With `CANVAS_BRUSH_3X3_EN` defined, paint (96,16) → row 0 = 28'h3 and row 1 = 28'h3.
